// File: rtl/stack_ctrl_pkg.sv
// Shared encodings for the stack arbiter: FSM states and request opcodes.
package stack_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer flips to the loser after each grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);
  logic ptr; // 0 favours r0, 1 favours r1

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)                    ptr <= 1'b0;
    else if (advance && |grant)   ptr <= grant[0];
  end
endmodule

// File: rtl/stack_arbiter.sv
// Shares one hardware stack between two requesters, sequencing the stack strobes
// and rejecting overflow/underflow so the stack never sees an illegal access.
module stack_arbiter
  import stack_ctrl_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             r0_req,
  input  logic             r0_op,
  input  logic [WIDTH-1:0] r0_wdata,
  output logic             r0_ack,
  output logic [WIDTH-1:0] r0_rdata,
  output logic             r0_err,
  input  logic             r1_req,
  input  logic             r1_op,
  input  logic [WIDTH-1:0] r1_wdata,
  output logic             r1_ack,
  output logic [WIDTH-1:0] r1_rdata,
  output logic             r1_err,
  output logic             stk_write_en,
  output logic             stk_read_en,
  output logic [WIDTH-1:0] stk_data_in,
  input  logic [WIDTH-1:0] stk_data_out,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  state_t           state, state_nxt;
  logic [1:0]       grant;
  logic             grant_now, sel, op_sel, op_q, gnt_q, err_q;
  logic             we_q, re_q;
  logic [WIDTH-1:0] wdata_sel, din_q, rdata_q;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     ({r1_req, r0_req}),
    .advance (grant_now),
    .grant   (grant)
  );

  assign grant_now = (state == IDLE) && |grant;
  assign sel       = grant[1];
  assign op_sel    = sel ? r1_op : r0_op;
  assign wdata_sel = sel ? r1_wdata : r0_wdata;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_now) state_nxt = ISSUE;
      ISSUE:   state_nxt = re_q ? WAIT : RESP;
      WAIT:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Legality is decided at grant so the strobes leave a register in ISSUE;
  // count cannot move between grant and ISSUE, so the decision still holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q   <= 1'b0;
      op_q    <= OP_PUSH;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      din_q   <= '0;
      rdata_q <= '0;
      count   <= '0;
    end else begin
      we_q  <= 1'b0;
      re_q  <= 1'b0;
      din_q <= '0;
      if (grant_now) begin
        gnt_q   <= sel;
        op_q    <= op_sel;
        rdata_q <= '0;
        err_q   <= (op_sel == OP_PUSH) ? full : empty;
        we_q    <= (op_sel == OP_PUSH) && !full;
        re_q    <= (op_sel == OP_POP)  && !empty;
        din_q   <= ((op_sel == OP_PUSH) && !full) ? wdata_sel : '0;
      end
      if (we_q) count <= count + CW'(1);
      if (re_q) count <= count - CW'(1);
      if (state == WAIT) rdata_q <= stk_data_out;
    end
  end

  assign stk_write_en = we_q;
  assign stk_read_en  = re_q;
  assign stk_data_in  = din_q;
  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);

  assign r0_ack   = (state == RESP) && !gnt_q;
  assign r1_ack   = (state == RESP) &&  gnt_q;
  assign r0_rdata = r0_ack ? rdata_q : '0;
  assign r1_rdata = r1_ack ? rdata_q : '0;
  assign r0_err   = r0_ack && err_q;
  assign r1_err   = r1_ack && err_q;
endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter with a behavioural LIFO standing in for the stack.
module tb_stack_arbiter;
  import stack_ctrl_pkg::*;
  localparam int DEPTH = 16;
  localparam int WIDTH = 32;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk = 1'b0, reset = 1'b1;
  logic r0_req = 0, r0_op = 0, r1_req = 0, r1_op = 0;
  logic [WIDTH-1:0] r0_wdata = '0, r1_wdata = '0;
  logic r0_ack, r0_err, r1_ack, r1_err, stk_write_en, stk_read_en, full, empty;
  logic [WIDTH-1:0] r0_rdata, r1_rdata, stk_data_in, stk_data_out;
  logic [CW-1:0] count;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  stack_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_op(r0_op), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack), .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_req(r1_req), .r1_op(r1_op), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack), .r1_rdata(r1_rdata), .r1_err(r1_err),
    .stk_write_en(stk_write_en), .stk_read_en(stk_read_en),
    .stk_data_in(stk_data_in), .stk_data_out(stk_data_out),
    .count(count), .full(full), .empty(empty)
  );

  // Behavioural LIFO: top of stack appears one cycle after read_en.
  logic [WIDTH-1:0] mem [DEPTH];
  int sp;
  always @(posedge clk) begin
    if (reset) begin
      sp <= 0;
      stk_data_out <= '0;
    end else begin
      if (stk_write_en && sp < DEPTH) begin
        mem[sp] <= stk_data_in;
        sp <= sp + 1;
      end
      if (stk_read_en && sp > 0) begin
        stk_data_out <= mem[sp-1];
        sp <= sp - 1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h", name, act, exp);
    end
  endtask

  // Structural invariants, every cycle outside reset.
  always @(negedge clk) begin
    if (!reset) begin
      chk("strobe_exclusive", {63'd0, stk_write_en && stk_read_en}, 64'd0);
      chk("din_idle_zero", (!stk_write_en) ? {32'd0, stk_data_in} : 64'd0, 64'd0);
      chk("ack_exclusive", {63'd0, r0_ack && r1_ack}, 64'd0);
      chk("r0_idle_zero", (!r0_ack) ? {31'd0, r0_err, r0_rdata} : 64'd0, 64'd0);
      chk("r1_idle_zero", (!r1_ack) ? {31'd0, r1_err, r1_rdata} : 64'd0, 64'd0);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    r0_req = 0; r1_req = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One transaction from requester r; returns edges-to-ack (-1 on timeout).
  task automatic txn(input int r, input logic op, input logic [WIDTH-1:0] d,
                     output int lat, output logic err, output logic [WIDTH-1:0] rd,
                     output int nwe, output int nre, output logic [WIDTH-1:0] din_seen);
    logic ack;
    lat = -1; err = 0; rd = '0; nwe = 0; nre = 0; din_seen = '0;
    @(negedge clk);
    if (r == 0) begin r0_op = op; r0_wdata = d; r0_req = 1; end
    else        begin r1_op = op; r1_wdata = d; r1_req = 1; end
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (stk_write_en) begin nwe++; din_seen = stk_data_in; end
      if (stk_read_en)  nre++;
      ack = (r == 0) ? r0_ack : r1_ack;
      if (ack) begin
        lat = n;
        err = (r == 0) ? r0_err : r1_err;
        rd  = (r == 0) ? r0_rdata : r1_rdata;
        break;
      end
    end
    r0_req = 0; r1_req = 0;
  endtask

  typedef struct {
    int               r;
    logic             op;
    logic [WIDTH-1:0] d;
    int               lat;
    logic             err;
    logic [WIDTH-1:0] rd;
    int               cnt;
  } vec_t;

  vec_t vt[10];

  initial begin
    int lat, nwe, nre, seq[$], r0_hits;
    logic err;
    logic [WIDTH-1:0] rd, dseen;

    vt[0] = '{0, OP_PUSH, 32'hA5, 2, 1'b0, 32'h0,  1};
    vt[1] = '{0, OP_PUSH, 32'h11, 2, 1'b0, 32'h0,  2};
    vt[2] = '{0, OP_PUSH, 32'h22, 2, 1'b0, 32'h0,  3};
    vt[3] = '{0, OP_POP,  32'h0,  3, 1'b0, 32'h22, 2};
    vt[4] = '{1, OP_POP,  32'h0,  3, 1'b0, 32'h11, 1};
    vt[5] = '{1, OP_POP,  32'h0,  3, 1'b0, 32'hA5, 0};
    vt[6] = '{0, OP_POP,  32'h0,  2, 1'b1, 32'h0,  0};
    vt[7] = '{1, OP_PUSH, 32'h5A, 2, 1'b0, 32'h0,  1};
    vt[8] = '{1, OP_POP,  32'h0,  3, 1'b0, 32'h5A, 0};
    vt[9] = '{1, OP_POP,  32'h0,  2, 1'b1, 32'h0,  0};

    do_reset();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_strobes", {stk_write_en, stk_read_en}, 0);
    chk("rst_acks", {r0_ack, r1_ack}, 0);

    foreach (vt[i]) begin
      txn(vt[i].r, vt[i].op, vt[i].d, lat, err, rd, nwe, nre, dseen);
      chk($sformatf("v%0d_lat", i), lat, vt[i].lat);
      chk($sformatf("v%0d_err", i), err, vt[i].err);
      chk($sformatf("v%0d_rdata", i), rd, vt[i].rd);
      chk($sformatf("v%0d_count", i), count, vt[i].cnt);
      chk($sformatf("v%0d_empty", i), empty, (vt[i].cnt == 0));
      chk($sformatf("v%0d_nwe", i), nwe, (vt[i].op == OP_PUSH && !vt[i].err));
      chk($sformatf("v%0d_nre", i), nre, (vt[i].op == OP_POP && !vt[i].err));
      if (vt[i].op == OP_PUSH && !vt[i].err) chk($sformatf("v%0d_din", i), dseen, vt[i].d);
    end

    // Fill to capacity, overflow, then pop the last value pushed.
    for (int i = 0; i < DEPTH; i++) begin
      txn(0, OP_PUSH, 32'h100 + i, lat, err, rd, nwe, nre, dseen);
      chk($sformatf("fill%0d_err", i), {lat[7:0], err}, {8'd2, 1'b0});
    end
    chk("full_count", count, 16);
    chk("full_flag", full, 1);
    txn(1, OP_PUSH, 32'hDEAD, lat, err, rd, nwe, nre, dseen);
    chk("ovf_lat", lat, 2);
    chk("ovf_err", err, 1);
    chk("ovf_nwe", nwe, 0);
    chk("ovf_count", count, 16);
    txn(0, OP_POP, 32'h0, lat, err, rd, nwe, nre, dseen);
    chk("ovf_pop_rdata", rd, 32'h10F);
    chk("ovf_pop_count", count, 15);
    chk("ovf_pop_full", full, 0);

    // Simultaneous requests: r0 keeps req high for a second push after its ack.
    do_reset();
    r0_op = OP_PUSH; r0_wdata = 32'h10; r1_op = OP_PUSH; r1_wdata = 32'h20;
    r0_req = 1; r1_req = 1;
    r0_hits = 0;
    for (int n = 0; n < 30 && seq.size() < 3; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (r0_ack) begin seq.push_back(0); r0_hits++; if (r0_hits == 2) r0_req = 0; end
      if (r1_ack) begin seq.push_back(1); r1_req = 0; end
    end
    r0_req = 0; r1_req = 0;
    chk("arb_acks", seq.size(), 3);
    if (seq.size() == 3) chk("arb_order", {seq[0][3:0], seq[1][3:0], seq[2][3:0]}, 12'h010);
    chk("arb_count", count, 3);

    // Reset while a pop sits in WAIT: aborted with no ack.
    @(negedge clk);
    r0_op = OP_POP; r0_req = 1;
    @(posedge clk); @(negedge clk);
    chk("abort_read_en", stk_read_en, 1);
    @(posedge clk); @(negedge clk);
    reset = 1; r0_req = 0;
    @(posedge clk); @(negedge clk);
    chk("abort_strobes", {stk_write_en, stk_read_en}, 0);
    chk("abort_count", count, 0);
    chk("abort_ack", {r0_ack, r1_ack}, 0);
    reset = 0;
    nwe = 0;
    repeat (5) begin
      @(posedge clk); @(negedge clk);
      if (r0_ack || r1_ack) nwe++;
    end
    chk("abort_no_ack", nwe, 0);
    txn(0, OP_PUSH, 32'h77, lat, err, rd, nwe, nre, dseen);
    chk("post_abort_lat", lat, 2);
    chk("post_abort_err", err, 0);
    chk("post_abort_count", count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
